// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, access-size encodings and alignment check for the data-memory port.
// Rev 1.0
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lane[0];
            default: r = (lane != 2'b00);
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_load_align.sv
// dmem_load_align: little-endian lane select with sign/zero extension, plus byte/half store merge.
// Rev 1.0
`default_nettype none

module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);

    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;

    always_comb begin
        w_shamt   = {i_lane, 3'b000};
        w_shifted = i_word >> w_shamt;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{(DATA_W-8){i_signed & w_shifted[7]}}, w_shifted[7:0]};
                w_mask = DATA_W'(8'hFF) << w_shamt;
            end
            SZ_HALF: begin
                o_load = {{(DATA_W-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};
                w_mask = DATA_W'(16'hFFFF) << w_shamt;
            end
            default: begin
                o_load = i_word;
                w_mask = '1;
            end
        endcase
        o_merged = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);
    end

endmodule

`default_nettype wire

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: wait-stated data memory with Stall handshake, sized accesses and misalignment flag.
// Optional macro DMEM_STALL_CNT_EN enables the saturating StallCount counter. Rev 1.0
`default_nettype none

module dmem_stall_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MisalignErr,
    output logic [31:0]       StallCount
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    localparam int c_CNT_W = $clog2(WAIT_CYCLES) + 1;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_store;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

    logic                w_req;
    logic                w_mis;
    logic                w_accept;
    logic                w_reject;
    logic                w_last;
    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_merged;
    logic                w_unused_addr;

    assign w_req         = MemRead | MemWrite;
    assign w_mis         = is_misaligned(MemSize, Address[1:0]);
    assign w_accept      = (r_state == ST_IDLE) && w_req && !w_mis;
    assign w_reject      = (r_state == ST_IDLE) && w_req && w_mis;
    assign w_last        = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_unused_addr = &{1'b0, Address[31:c_IDX_W+2]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_WAIT;
            ST_WAIT: if (r_cnt == '0) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Stall       = w_accept || (r_state == ST_WAIT);
        MisalignErr = w_reject;
        ReadData    = w_reject ? '0 : r_rdata;
    end

    dmem_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_word   (r_mem[r_idx]),
        .i_wdata  (r_wdata),
        .i_lane   (r_lane),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_idx    <= '0;
            r_lane   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_store  <= 1'b0;
            r_wdata  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt    <= c_CNT_W'(WAIT_CYCLES - 1);
                r_idx    <= Address[c_IDX_W+1:2];
                r_lane   <= Address[1:0];
                r_size   <= MemSize;
                r_signed <= MemSigned;
                r_store  <= MemWrite;
                r_wdata  <= WriteData;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                r_rdata <= r_store ? '0 : w_load;
            end
        end
    end

    // Storage is never cleared; a reset during WAIT drops the pending store.
    always_ff @(posedge Clk) begin
        if (w_last && r_store && !Reset) begin
            r_mem[r_idx] <= w_merged;
        end
    end

`ifdef DMEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (Stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign StallCount = r_stall_cnt;
`else
    assign StallCount = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: directed and randomized accesses checked against a word-array reference model.
// Rev 1.0
`default_nettype none

module tb_dmem_stall_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int W      = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;
    logic [31:0] StallCount;

    dmem_stall_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSize     (MemSize),
        .MemSigned   (MemSigned),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .MisalignErr (MisalignErr),
        .StallCount  (StallCount)
    );

    always #5 Clk = ~Clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd;
    logic [31:0] obs_rd;
    int          stall_cycles;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] exp_stall_count();
`ifdef DMEM_STALL_CNT_EN
        return 32'(stall_cycles);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input int idx, input int lane,
                                               input logic [1:0] sz, input bit sg);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem_m[idx];
        case (sz)
            2'b00: begin
                b = w[lane*8 +: 8];
                return sg ? 32'($signed(b)) : {24'b0, b};
            end
            2'b01: begin
                h = w[lane*8 +: 16];
                return sg ? 32'($signed(h)) : {16'b0, h};
            end
            default: return w;
        endcase
    endfunction

    task automatic release_bus();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Called just after a clock edge with the DUT idle; leaves it idle again.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          idx;
        int          lane;
        bit          mis;
        logic [31:0] exp;
        idx  = int'(addr[9:2]);
        lane = int'(addr[1:0]);
        mis  = (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
        Address = addr; WriteData = wdata;
        #1;
        if (mis) begin
            check("mis_err", {31'b0, MisalignErr}, 32'd1);
            check("mis_stall", {31'b0, Stall}, 32'd0);
            check("mis_rdata", ReadData, 32'd0);
            release_bus();
            cyc();
            check("mis_idle_stall", {31'b0, Stall}, 32'd0);
            check("mis_hold_rdata", ReadData, last_rd);
            return;
        end
        if (wr) begin
            case (sz)
                2'b00:   mem_m[idx][lane*8 +: 8]  = wdata[7:0];
                2'b01:   mem_m[idx][lane*8 +: 16] = wdata[15:0];
                default: mem_m[idx] = wdata;
            endcase
            exp = 32'd0;
        end else begin
            exp = model_load(idx, lane, sz, sg);
        end
        check("req_stall", {31'b0, Stall}, 32'd1);
        check("req_mis", {31'b0, MisalignErr}, 32'd0);
        for (int i = 0; i < W; i++) begin
            cyc();
            check("wait_stall", {31'b0, Stall}, 32'd1);
        end
        cyc();
        stall_cycles += W + 1;
        check("done_stall", {31'b0, Stall}, 32'd0);
        check("done_rdata", ReadData, exp);
        check("stall_cnt", StallCount, exp_stall_count());
        obs_rd  = ReadData;
        last_rd = exp;
        release_bus();
        cyc();
        check("idle_hold", ReadData, last_rd);
    endtask

    initial begin
        logic [31:0] old20;
        Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b10;
        MemSigned = 1'b0; Address = '0; WriteData = '0;
        stall_cycles = 0; last_rd = '0; obs_rd = '0;
        cyc();
        cyc();
        check("rst_stall", {31'b0, Stall}, 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_mis", {31'b0, MisalignErr}, 32'd0);
        check("rst_cnt", StallCount, 32'd0);
        Reset = 1'b0;
        cyc();

        access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0);
        check("lit_word", obs_rd, 32'hDEADBEEF);

        access(0, 1, 2'b10, 0, 32'h10, 32'h0);
        access(0, 1, 2'b00, 0, 32'h11, 32'h80);
        access(1, 0, 2'b00, 1, 32'h11, 32'h0);
        check("lit_byte_s", obs_rd, 32'hFFFFFF80);
        access(1, 0, 2'b00, 0, 32'h11, 32'h0);
        check("lit_byte_u", obs_rd, 32'h00000080);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0);
        check("lit_merge", obs_rd, 32'h00008000);

        access(1, 0, 2'b01, 0, 32'h13, 32'h0);
        access(0, 1, 2'b10, 0, 32'h12, 32'hFFFFFFFF);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0);
        check("lit_mis_nowr", obs_rd, 32'h00008000);

        // Reset lands in the final WAIT cycle of a store, which must not commit.
        access(0, 1, 2'b10, 0, 32'h20, 32'h11111111);
        old20 = mem_m[8];
        MemWrite = 1'b1; MemRead = 1'b0; MemSize = 2'b10;
        Address = 32'h20; WriteData = 32'h12345678;
        cyc();
        cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        release_bus();
        #1;
        check("rst_mid_stall", {31'b0, Stall}, 32'd0);
        check("rst_mid_rdata", ReadData, 32'd0);
        stall_cycles = 0;
        last_rd = '0;
        check("rst_mid_cnt", StallCount, exp_stall_count());
        cyc();
        access(1, 0, 2'b10, 0, 32'h20, 32'h0);
        check("lit_rst_abort", obs_rd, old20);

        access(0, 1, 2'b10, 0, 32'h400, 32'hA5A5A5A5);
        access(1, 0, 2'b10, 0, 32'h000, 32'h0);
        check("lit_wrap", obs_rd, 32'hA5A5A5A5);
        access(1, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D);
        check("lit_both_rd", obs_rd, 32'h0);
        access(1, 0, 2'b10, 0, 32'h30, 32'h0);
        check("lit_both_wr", obs_rd, 32'hCAFEF00D);

        for (int i = 0; i < 16; i++) begin
            access(0, 1, 2'b10, 0, {$urandom_range(0, 3), 22'b0, 8'(i), 2'b00}, $urandom);
        end
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          op;
            op = $urandom_range(0, 9);
            a  = {22'($urandom), 4'b0000, 4'($urandom_range(0, 15)), 2'($urandom)};
            access(op < 5, op >= 4, 2'($urandom), 1'($urandom), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
Parametrised data-memory block with its own storage. It replaces the single-cycle data memory on the MIPS core's data port.
- Adds configurable wait states, with a Stall output back to the core.
- Adds byte/half/word access sizes with load sign/zero extension.
- Adds misalignment detection.
It sits beside the processor core in the top level and is driven directly by the core's MemRead/MemWrite/Address/WriteData.

Parameters:
DATA_W, 32, data width in bits (multiple of 8)
DEPTH_WORDS, 256, memory depth in DATA_W words (power of 2)
WAIT_CYCLES, 2, stall cycles per access (>=1)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
MemRead  in  1  load request
MemWrite  in  1  store request
MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
MemSigned  in  1  1 = sign-extend byte/half loads, 0 = zero-extend
Address  in  32  byte address
WriteData  in  DATA_W  store data, right-aligned for byte/half
ReadData  out  DATA_W  extended load data, valid in DONE
Stall  out  1  core must hold PC and its outputs while high
MisalignErr  out  1  one-cycle flag for a misaligned request
StallCount  out  32  stalled-cycle count (optional feature)

Behaviour:
- Clocking: single clock Clk; Reset synchronous, active-high.
- Reset values:
  - state IDLE, wait counter 0.
  - Stall 0, ReadData 0, MisalignErr 0, StallCount 0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE, req = MemRead|MemWrite:
  - Aligned req: capture Address/WriteData/MemSize/MemSigned/op, load counter = WAIT_CYCLES-1, go to WAIT. Stall is combinationally high in this same cycle.
  - Misaligned req (half with Address[0]=1, word with Address[1:0]!=0): MisalignErr=1 combinationally, Stall=0, no memory access, stay IDLE, ReadData 0.
- WAIT:
  - Stall=1.
  - Counter decrements each cycle; at 0, go to DONE.
  - Leaving WAIT, a store commits to memory on that edge; a load registers the extended data into ReadData.
- DONE:
  - Stall=0 and ReadData valid; the core completes the instruction at the end of this cycle.
  - Request inputs are ignored (same instruction); go to IDLE.
- Latency: request in cycle t gives Stall high for cycles t..t+WAIT_CYCLES and DONE at cycle t+WAIT_CYCLES+1.
- MemRead and MemWrite both high: treated as a store; ReadData 0 in DONE.
- Addressing:
  - Word index = Address[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so addresses wrap.
  - Byte lane = Address[1:0], little-endian.
- Store merge: byte/half stores modify only the addressed lanes (read-modify-write on the stored word).
- Load extension: selected lane(s) shifted to bit 0, then sign- or zero-extended per MemSigned.
- ReadData holds its last value outside DONE, and is cleared for stores.
- Reset mid-access (WAIT): access aborted, pending store not committed, FSM to IDLE.

Optional Feature:
Macro DMEM_STALL_CNT_EN.
- Defined: StallCount increments by 1 on every cycle Stall=1 and saturates at 32'hFFFFFFFF. It is cleared only by Reset.
- Undefined: StallCount tied to 0, no counter logic.

Decomposition:
- Shared package dmem_pkg holds:
  - the FSM state enum (IDLE/WAIT/DONE),
  - MemSize encodings SZ_BYTE/SZ_HALF/SZ_WORD,
  - a function for misalignment check.
- One natural sub-module: dmem_load_align (combinational lane select plus sign/zero extend, and store-lane merge). It is reused by a future instruction-side port.

Test Plan:
- Word store then load, WAIT_CYCLES=2: store 0xDEADBEEF @0x10, then load word @0x10 -> Stall high 3 cycles per access; DONE ReadData=0xDEADBEEF.
- Byte merge and extension: store byte 0x80 @0x11 over 0x00000000, then load byte signed @0x11 -> 0xFFFFFF80. Load byte unsigned -> 0x00000080. Load word @0x10 -> 0x00008000.
- Misaligned half load @0x13 -> MisalignErr=1 that cycle, Stall=0, memory unchanged, FSM stays IDLE.
- Reset asserted in second WAIT cycle of store 0x12345678 @0x20 -> Stall 0 next cycle; later load @0x20 returns previous contents.
- Wrap-around, DEPTH_WORDS=256: store 0xA5A5A5A5 @0x400, load @0x000 -> 0xA5A5A5A5. MemRead and MemWrite both high -> store performed, ReadData=0.
- With DMEM_STALL_CNT_EN: two accesses at WAIT_CYCLES=3 -> StallCount=8. Without the macro -> StallCount stays 0.
